// File: rtl/fruit_projectile.sv
// One fruit sprite: parks while idle, flies a gravity arc with X wall bounce, drops straight once sliced.
// Registered outputs update one frame_clk edge after inputs are sampled; no backpressure, Pause freezes all state.
module fruit_projectile #(
  parameter int SIZE     = 16,
  parameter int PARK_X   = 320,
  parameter int PARK_Y   = 240,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479,
  parameter int GRAVITY  = 1,
  parameter int VY_MAX   = 15,
  parameter int SLICE_VY = 4
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       Pause,
  input  logic       Launch,
  input  logic [9:0] Launch_X,
  input  logic [7:0] Launch_VX,
  input  logic [7:0] Launch_VY,
  input  logic       Slice,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] BallS,
  output logic       Active,
  output logic       Missed,
  output logic       Done
);

  typedef enum logic [1:0] {IDLE, FLYING, SLICED} state_t;

  localparam logic signed [13:0] X_RIGHT = 14'(X_MAX - SIZE);
  localparam logic signed [13:0] X_LEFT  = 14'(X_MIN + SIZE);
  localparam logic signed [13:0] Y_EXIT  = 14'(Y_MAX + SIZE);
  localparam logic signed [13:0] SVY14   = 14'(SLICE_VY);
  localparam logic signed [10:0] PX      = 11'(PARK_X);
  localparam logic signed [11:0] PY      = 12'(PARK_Y);
  localparam logic signed [11:0] Y_START = 12'(Y_MAX);
  localparam logic signed [7:0]  SVY8    = 8'(SLICE_VY);
  localparam logic signed [9:0]  GRV10   = 10'(GRAVITY);
  localparam logic signed [9:0]  VYM10   = 10'(VY_MAX);
  localparam logic signed [7:0]  VYM8    = 8'(VY_MAX);

  state_t             state_q, state_d;
  logic signed [10:0] x_q, x_d;
  logic signed [11:0] y_q, y_d;
  logic signed [7:0]  vx_q, vx_d, vy_q, vy_d;
  logic               missed_q, missed_d, done_q, done_d;

  logic signed [13:0] xn, yn;
  logic signed [9:0]  vy_acc;
  logic               exit_hit;

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      x_q      <= PX;
      y_q      <= PY;
      vx_q     <= '0;
      vy_q     <= '0;
      missed_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      missed_q <= missed_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    missed_d = 1'b0;
    done_d   = 1'b0;

    xn       = 14'(x_q) + 14'(vx_q);
    yn       = 14'(y_q) + ((state_q == SLICED) ? SVY14 : 14'(vy_q));
    vy_acc   = 10'(vy_q) + GRV10;
    // Exit only counts on the way down; a sliced fruit always falls.
    exit_hit = ((state_q == SLICED) || !vy_q[7]) && (yn > Y_EXIT);

    if (!Pause) begin
      case (state_q)
        IDLE: begin
          if (Launch) begin
            state_d = FLYING;
            x_d     = {1'b0, Launch_X};
            y_d     = Y_START;
            vx_d    = Launch_VX;
            vy_d    = Launch_VY;
          end
        end
        FLYING: begin
          if (xn > X_RIGHT) begin
            x_d  = X_RIGHT[10:0];
            vx_d = -vx_q;
          end else if (xn < X_LEFT) begin
            x_d  = X_LEFT[10:0];
            vx_d = -vx_q;
          end else begin
            x_d  = xn[10:0];
          end
          y_d  = yn[11:0];
          vy_d = (vy_acc > VYM10) ? VYM8 : vy_acc[7:0];
          // The position step above still uses the pre-slice velocity.
          if (Slice) begin
            state_d = SLICED;
            vx_d    = '0;
            vy_d    = SVY8;
          end
        end
        SLICED: begin
          y_d = yn[11:0];
        end
        default: state_d = IDLE;
      endcase

      // Leaving the screen overrides everything, including a same-edge slice.
      if ((state_q != IDLE) && exit_hit) begin
        state_d  = IDLE;
        x_d      = PX;
        y_d      = PY;
        vx_d     = '0;
        vy_d     = '0;
        missed_d = (state_q == FLYING);
        done_d   = (state_q == SLICED);
      end
    end
  end

  assign BallX  = x_q[9:0];
  assign BallY  = y_q[11] ? 10'd0 : y_q[9:0];
  assign BallS  = 10'(SIZE);
  assign Active = (state_q != IDLE);
  assign Missed = missed_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_fruit_projectile.sv
// Bench for fruit_projectile: behavioural flight model compared every cycle, plus pinned literal points.
module tb_fruit_projectile;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1, Pause = 1'b0, Launch = 1'b0, Slice = 1'b0;
  logic [9:0] Launch_X = '0;
  logic [7:0] Launch_VX = '0, Launch_VY = '0;
  logic [9:0] BallX, BallY, BallS;
  logic       Active, Missed, Done;

  int checks = 0;
  int errors = 0;

  // Model state: 0 idle, 1 flying, 2 sliced; positions/velocities as plain ints.
  int m_st = 0, m_x = 320, m_y = 240, m_vx = 0, m_vy = 0;
  bit m_miss = 0, m_done = 0, m_ok = 0;

  always #5 frame_clk = ~frame_clk;

  fruit_projectile dut (
    .frame_clk(frame_clk), .Reset(Reset), .Pause(Pause), .Launch(Launch),
    .Launch_X(Launch_X), .Launch_VX(Launch_VX), .Launch_VY(Launch_VY), .Slice(Slice),
    .BallX(BallX), .BallY(BallY), .BallS(BallS), .Active(Active), .Missed(Missed), .Done(Done)
  );

  function automatic int wrap8(input int v);
    byte b;
    b = byte'(v);
    return int'(b);
  endfunction

  function automatic int wrap12(input int v);
    logic signed [11:0] t;
    t = 12'(v);
    return int'(t);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic park();
    m_st = 0; m_x = 320; m_y = 240; m_vx = 0; m_vy = 0;
  endtask

  // One frame of the flight rules, evaluated with the inputs present at the edge.
  task automatic model_tick();
    int xn, yn;
    if (Reset) begin
      park();
      m_miss = 0; m_done = 0; m_ok = 1;
    end else if (m_ok) begin
      m_miss = 0; m_done = 0;
      if (!Pause) begin
        if (m_st == 0) begin
          if (Launch) begin
            m_st = 1; m_x = int'(Launch_X); m_y = 479;
            m_vx = int'($signed(Launch_VX)); m_vy = int'($signed(Launch_VY));
          end
        end else if (m_st == 1) begin
          yn = m_y + m_vy;
          if (m_vy >= 0 && yn > 495) begin
            park(); m_miss = 1;
          end else begin
            xn = m_x + m_vx;
            if (xn + 16 > 639) begin m_x = 623; m_vx = wrap8(-m_vx); end
            else if (xn - 16 < 0) begin m_x = 16; m_vx = wrap8(-m_vx); end
            else m_x = xn;
            m_y = wrap12(yn);
            m_vy = (m_vy + 1 > 15) ? 15 : m_vy + 1;
            if (Slice) begin m_st = 2; m_vx = 0; m_vy = 4; end
          end
        end else begin
          yn = m_y + 4;
          if (yn > 495) begin park(); m_done = 1; end
          else m_y = yn;
        end
      end
    end
  endtask

  task automatic compare();
    if (m_ok) begin
      chk("BallX", int'(BallX), m_x & 1023);
      chk("BallY", int'(BallY), (m_y < 0) ? 0 : (m_y & 1023));
      chk("BallS", int'(BallS), 16);
      chk("Active", int'(Active), (m_st != 0) ? 1 : 0);
      chk("Missed", int'(Missed), int'(m_miss));
      chk("Done", int'(Done), int'(m_done));
    end
  endtask

  task automatic step();
    @(posedge frame_clk);
    model_tick();
    @(negedge frame_clk);
    compare();
  endtask

  task automatic launch(input int x, input int vx, input int vy);
    Launch_X = 10'(x); Launch_VX = 8'(vx); Launch_VY = 8'(vy);
    Launch = 1'b1;
    step();
    Launch = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, input string nm);
    int n;
    n = 0;
    while (Active && n < budget) begin
      step();
      n++;
    end
    chk(nm, int'(Active), 0);
  endtask

  initial begin
    // Power-on reset
    Reset = 1'b1; step(); step();
    Reset = 1'b0;
    chk("rst_x", int'(BallX), 320);
    chk("rst_y", int'(BallY), 240);
    chk("rst_act", int'(Active), 0);

    // Full miss trajectory
    launch(100, 2, -10);
    chk("l_x", int'(BallX), 100);
    chk("l_y", int'(BallY), 479);
    chk("l_act", int'(Active), 1);
    repeat (10) step();
    chk("apex_x", int'(BallX), 120);
    chk("apex_y", int'(BallY), 424);
    chk("apex_mvy", m_vy, 0);
    repeat (10) step();
    chk("d10_x", int'(BallX), 140);
    chk("d10_y", int'(BallY), 469);
    chk("d10_mvy", m_vy, 10);
    step(); chk("d11_y", int'(BallY), 479);
    step(); chk("d12_y", int'(BallY), 490);
    step();
    chk("miss_pulse", int'(Missed), 1);
    chk("miss_x", int'(BallX), 320);
    chk("miss_y", int'(BallY), 240);
    chk("miss_act", int'(Active), 0);
    step(); chk("miss_clear", int'(Missed), 0);

    // Wall bounces
    launch(620, 5, -10);
    step(); chk("bounce_r", int'(BallX), 623); chk("bounce_r_mvx", m_vx, -5);
    step(); chk("bounce_r2", int'(BallX), 618);
    Reset = 1'b1; step(); Reset = 1'b0;
    launch(20, -6, -10);
    step(); chk("bounce_l", int'(BallX), 16);
    step(); chk("bounce_l2", int'(BallX), 22);

    // Reset held two edges mid-flight
    Launch = 1'b1; Slice = 1'b1; Pause = 1'b1;
    Reset = 1'b1; step(); step();
    Reset = 1'b0; Launch = 1'b0; Slice = 1'b0; Pause = 1'b0;
    chk("mid_rst_x", int'(BallX), 320);
    chk("mid_rst_y", int'(BallY), 240);
    chk("mid_rst_s", int'(BallS), 16);
    chk("mid_rst_act", int'(Active), 0);
    chk("mid_rst_pulse", int'(Missed) + int'(Done), 0);

    // Slice at the apex
    launch(100, 2, -10);
    repeat (10) step();
    Slice = 1'b1; step(); Slice = 1'b0;
    chk("slice_y", int'(BallY), 424);
    chk("slice_x", int'(BallX), 122);
    repeat (17) step();
    chk("drop_y", int'(BallY), 492);
    chk("drop_x", int'(BallX), 122);
    chk("drop_done0", int'(Done), 0);
    step();
    chk("done_pulse", int'(Done), 1);
    chk("done_nomiss", int'(Missed), 0);
    chk("done_act", int'(Active), 0);
    step(); chk("done_clear", int'(Done), 0);

    // Pause freezes mid-flight, ignoring Launch/Slice
    launch(100, 2, -10);
    repeat (3) step();
    chk("pre_pause_x", int'(BallX), 106);
    chk("pre_pause_y", int'(BallY), 452);
    Pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      Launch = i[0]; Slice = ~i[0];
      step();
      chk("pause_x", int'(BallX), 106);
      chk("pause_y", int'(BallY), 452);
    end
    Pause = 1'b0; Launch = 1'b0; Slice = 1'b0;
    step();
    chk("resume_x", int'(BallX), 108);
    chk("resume_y", int'(BallY), 445);
    run_until_idle(200, "pause_flight_end");

    // Very fast launch: above the top of the screen, saturating descent
    launch(300, 0, -127);
    repeat (4) step();
    chk("neg_y_out", int'(BallY), 0);
    chk("neg_y_model", m_y, -23);
    chk("neg_act", int'(Active), 1);
    run_until_idle(600, "fast_flight_end");
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      Reset     = ($urandom_range(0, 299) == 0);
      Pause     = ($urandom_range(0, 9) == 0);
      Launch    = ($urandom_range(0, 3) == 0);
      Slice     = ($urandom_range(0, 29) == 0);
      Launch_X  = 10'($urandom_range(0, 1023));
      Launch_VX = 8'($urandom);
      Launch_VY = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(-int'($urandom_range(5, 30)));
      step();
    end
    Reset = 1'b0; Pause = 1'b0; Launch = 1'b0; Slice = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
